stream_demux_1_4: RTL

Registered 1-to-4 stream demultiplexer: accepts one upstream word per cycle on a valid/ready handshake and delivers it to exactly one of four downstream sinks, selected either by an explicit 2-bit destination or by an internal round-robin pointer. It is the distribution end of the 4:1 selection path: the mux gathers four 4-bit sources onto one bus, and this block fans one bus back out to four consumers with flow control. One pipeline register, no combinational path from upstream data to downstream outputs.

---
 rtl/stream_demux_1_4.sv | 82 ++++++++
 1 files changed

// File: rtl/stream_demux_1_4.sv
// Registered 1-to-4 stream demultiplexer: one holding register fans a valid/ready
// stream out to four sinks, routed by explicit select or a round-robin pointer.
module stream_demux_1_4 #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         up_valid,
   output logic         up_ready,
   input  logic [W-1:0] up_data,
   input  logic [1:0]   up_sel,
   input  logic         rr_en,
   output logic [3:0]   down_valid,
   input  logic [3:0]   down_ready,
   output logic [W-1:0] down_data,
   output logic [1:0]   rr_ptr,
   output logic [7:0]   xfer_cnt
);

   typedef enum logic {EMPTY = 1'b0, HOLD = 1'b1} state_t;

   state_t       state_q, state_d;
   logic [1:0]   dst_q, dst_d;
   logic [W-1:0] data_q, data_d;
   logic [1:0]   rr_ptr_q, rr_ptr_d;
   logic [7:0]   xfer_cnt_q, xfer_cnt_d;

   logic full;
   logic drain;
   logic accept;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= EMPTY;
         dst_q      <= 2'd0;
         data_q     <= '0;
         rr_ptr_q   <= 2'd0;
         xfer_cnt_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         dst_q      <= dst_d;
         data_q     <= data_d;
         rr_ptr_q   <= rr_ptr_d;
         xfer_cnt_q <= xfer_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      dst_d      = dst_q;
      data_d     = data_q;
      rr_ptr_d   = rr_ptr_q;
      xfer_cnt_d = xfer_cnt_q;

      full   = (state_q == HOLD);
      // Only the held word's sink gates the upstream; up_valid never feeds up_ready.
      drain  = full && down_ready[dst_q];
      up_ready = !full || down_ready[dst_q];
      accept = up_valid && up_ready;

      case (state_q)
         EMPTY: if (accept) state_d = HOLD;
         HOLD:  if (drain && !accept) state_d = EMPTY;
         default: state_d = EMPTY;
      endcase

      if (accept) begin
         data_d = up_data;
         dst_d  = rr_en ? rr_ptr_q : up_sel;
         if (rr_en) rr_ptr_d = rr_ptr_q + 2'd1;
      end

      if (drain) xfer_cnt_d = xfer_cnt_q + 8'd1;

      down_valid = full ? (4'b0001 << dst_q) : 4'b0000;
   end

   assign down_data = data_q;
   assign rr_ptr    = rr_ptr_q;
   assign xfer_cnt  = xfer_cnt_q;

endmodule
